// File: rtl/skid_buffer_pkg.sv
// skid_buffer_pkg: shared state encoding and depth for the skid buffer slice
package skid_buffer_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    localparam int DEPTH = 2;
endpackage

// File: rtl/skid_buffer_if.sv
// skid_buffer_if: producer/consumer valid-ready handshake bundle around the skid buffer
interface skid_buffer_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/skid_buffer_en_reg.sv
// skid_buffer_en_reg: enable-controlled data register with async active-high reset to zero
module skid_buffer_en_reg #(parameter int WIDTH = 8) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) data_q <= '0;
        else if (en_i) data_q <= d_i;
    assign q_o = data_q;
endmodule

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready slice with registered ready/valid and full throughput
module skid_buffer
    import skid_buffer_pkg::*;
#(parameter int WIDTH = 8) (
    input logic          clk,
    input logic          rst,
    skid_buffer_if.slave bus
);
    state_t           state_q, state_d;
    logic             in_ready_q;
    logic             in_xfer, out_xfer, load_main, load_skid, sel_skid;
    logic [WIDTH-1:0] skid_data;
    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = bus.out_valid & bus.out_ready;
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        case (state_q)
            EMPTY: begin
                load_main = in_xfer;
                state_d   = in_xfer ? ONE : EMPTY;
            end
            ONE: begin
                load_main = in_xfer & out_xfer;
                load_skid = in_xfer & ~out_xfer;
                state_d   = (in_xfer & ~out_xfer) ? FULL : (out_xfer & ~in_xfer) ? EMPTY : ONE;
            end
            FULL: begin
                load_main = out_xfer;
                sel_skid  = 1'b1;
                state_d   = out_xfer ? ONE : FULL;
            end
            default: state_d = EMPTY;
        endcase
    end
    // ready is registered from next state so out_ready never reaches in_ready combinationally
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_d != FULL;
        end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = state_q != EMPTY;
    skid_buffer_en_reg #(.WIDTH(WIDTH)) u_main (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_main),
        .d_i  (sel_skid ? skid_data : bus.in_data),
        .q_o  (bus.out_data)
    );
    skid_buffer_en_reg #(.WIDTH(WIDTH)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .en_i (load_skid),
        .d_i  (bus.in_data),
        .q_o  (skid_data)
    );
endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed vector table plus scoreboarded random stalls for skid_buffer
module tb_skid_buffer;
    import skid_buffer_pkg::*;
    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs[10];
    logic [7:0] q[$];
    logic       stall_prev;
    logic [7:0] prev_data;
    logic [7:0] seq;
    skid_buffer_if #(.WIDTH(8)) bus();
    skid_buffer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // one scoreboarded cycle: drive, observe at negedge, then cross the edge
    task automatic sb_cycle(input logic iv, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = seq;
        bus.out_ready = ordy;
        @(negedge clk);
        chk("occ_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
        chk("occ_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < DEPTH});
        if (stall_prev) chk("stable", {24'b0, bus.out_data}, {24'b0, prev_data});
        if (bus.out_valid && bus.out_ready && q.size() != 0) chk("order", {24'b0, bus.out_data}, {24'b0, q.pop_front()});
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(bus.in_data);
            seq++;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        step();
    endtask
    initial begin
        vecs[0] = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5};
        vecs[2] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[4] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[5] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[6] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[7] = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33};
        vecs[9] = '{1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h33};
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        stall_prev    = 1'b0;
        prev_data     = 8'h00;
        seq           = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        rst = 1'b0;
        chk("release_in_ready", {31'b0, bus.in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].exp_ir});
            chk($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_out_data", i), {24'b0, bus.out_data}, {24'b0, vecs[i].exp_od});
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            step();
            chk("stream_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("stream_data", {24'b0, bus.out_data}, i);
            chk("stream_ready", {31'b0, bus.in_ready}, 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_end_valid", {31'b0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 1000; i++)
            sb_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) sb_cycle(1'b0, 1'b1);
        chk("drained", q.size(), 32'd0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h44;
        step();
        bus.in_data = 8'h55;
        step();
        bus.in_valid = 1'b0;
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("full_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("full_out_data", {24'b0, bus.out_data}, 32'h44);
        #3 rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("async_out_data", {24'b0, bus.out_data}, 32'h00);
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("post_rst_data", {24'b0, bus.out_data}, 32'h00);
        end
        chk("post_rst_ready", {31'b0, bus.in_ready}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
Two-entry valid/ready pipeline slice that sits directly upstream of an enable-controlled data register and produces its load-enable and data. It breaks the combinational ready path between producer and consumer and keeps full throughput (one transfer per cycle) with no bubbles. Data storage uses two instances of the team's enable-register block. Handshake control is a small state machine.

Parameters:
WIDTH, 8, data width in bits of in_data/out_data.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  producer presents in_data this cycle.
in_ready  output  1  buffer can accept; registered output.
in_data  input  WIDTH  producer data.
out_valid  output  1  out_data holds a valid word; registered output.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  WIDTH  head word, driven straight from main register.

Behaviour:
- Transfer rules: an input transfer happens when in_valid and in_ready are both high at a posedge. An output transfer happens when out_valid and out_ready are both high at a posedge.
- Storage: main register (head, drives out_data) and skid register (overflow). Each is an enable-register with async reset to '0.
- States (state_t):
  - EMPTY: 0 words.
  - ONE: main valid.
  - FULL: main and skid valid.
- Outputs by state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL), held in a flop loaded from next-state.
- Transitions:
  - EMPTY, in xfer: main <= in_data; go to ONE.
  - ONE, in xfer and out xfer: main <= in_data; stay in ONE.
  - ONE, in xfer only: skid <= in_data; go to FULL. main holds.
  - ONE, out xfer only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, out xfer: main <= skid; go to ONE. in_valid is ignored because in_ready is 0.
  - FULL, no out xfer: hold. main and skid are stable.
- Latency: a word accepted at edge N is visible on out_data with out_valid=1 after edge N (one cycle). Throughput is 1 word/cycle in steady ONE state with both sides ready.
- Ordering: strict FIFO. A skid word never overtakes the main word.
- Reset:
  - rst high, at any time including mid-transfer: state=EMPTY, out_valid=0, in_ready=0, main=skid='0. Buffered words are discarded.
  - in_ready rises to 1 at the first posedge after rst deasserts. No input is accepted on that edge.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold unchanged.
- Ignored inputs: in_data is ignored when no input transfer occurs. out_ready is ignored when out_valid=0.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Decomposition:
- Package skid_buffer_pkg holds:
  - typedef enum logic [1:0] state_t {EMPTY, ONE, FULL}.
  - localparam DEPTH = 2 for bench reference.
- Sub-module: existing enable-register block, instantiated twice.
  - main: en = load_main, in = mux(skid, in_data).
  - skid: en = load_skid.
- Control FSM stays in skid_buffer.

Test Plan:
1. Reset release: hold rst 3 cycles, then drop it. Expect in_ready=0 and out_valid=0 during reset, in_ready=1 one edge after release, out_data=8'h00.
2. Single word: in_valid=1, in_data=8'hA5 for one accepted edge, out_ready=1. Expect out_valid=1 and out_data=A5 the next cycle, then EMPTY (out_valid=0).
3. Stream: out_ready=1, in_valid=1 with data 01..10 on consecutive cycles. Expect out_data 01..10 on consecutive cycles, no bubbles, in_ready constantly 1.
4. Backpressure: out_ready=0, send 8'h11 then 8'h22. Expect in_ready=0 after the second accept; 8'h33 held on in_data is not accepted. Then set out_ready=1 and expect the output order 11, 22, 33.
5. Random stalls: random in_valid/out_ready over 1000 cycles. Scoreboard must show no drops, no duplicates, order preserved, and out_data stable whenever out_valid and !out_ready.
6. Mid-operation reset: reach FULL holding 8'h44/8'h55, assert rst between edges. Expect out_valid=0 and in_ready=0 immediately (async), and no 44/55 emitted after release.
